// File: rtl/morty_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : morty_fetch_unit
// Description : RV32I instruction fetch stage. Owns the PC, runs a Wishbone
//               classic read master and hands instructions to decode with a
//               valid/ready handshake. Define MORTY_IF_EXC_EN to report
//               misaligned-fetch and access-fault exceptions.
// Revision    : 1.0 - initial release
// ============================================================================
module morty_fetch_unit #(
    parameter logic [31:0] RESET_ADDR = 32'h8000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic [31:0] iwbm_addr_o,
    output logic        iwbm_cyc_o,
    output logic        iwbm_stb_o,
    input  logic [31:0] iwbm_dat_i,
    input  logic        iwbm_ack_i,
    input  logic        iwbm_err_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    output logic        exc_o,
    output logic [3:0]  exc_cause_o
);

`ifdef MORTY_IF_EXC_EN
    localparam logic c_exc_en = 1'b1;
`else
    localparam logic c_exc_en = 1'b0;
`endif

    localparam logic [31:0] c_nop = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_HOLD = 2'd1,
        S_KILL = 2'd2
    } state_t;

    state_t      r_state, w_state;
    logic [31:0] r_pc, w_pc;
    logic        r_cyc;
    logic [31:0] r_inst, w_inst;
    logic [31:0] r_pc_o, w_pc_o;
    logic        r_valid, w_valid;
    logic        r_exc, w_exc;
    logic [3:0]  r_cause, w_cause;

    logic        w_ack, w_err, w_done;
    logic [31:0] w_target;
    logic        w_tgt_mis, w_pc_mis, w_mis_entry;

    // Bus responses only count while our own cycle is open (ignores late acks after reset)
    assign w_ack  = iwbm_ack_i & r_cyc;
    assign w_err  = iwbm_err_i & r_cyc;
    assign w_done = w_ack | w_err;

    assign w_tgt_mis = c_exc_en & (|redirect_pc_i[1:0]);
    assign w_pc_mis  = c_exc_en & (|r_pc[1:0]);
    assign w_target  = c_exc_en ? redirect_pc_i : {redirect_pc_i[31:2], 2'b00};

    always_comb begin
        w_state     = r_state;
        w_pc        = r_pc;
        w_inst      = r_inst;
        w_pc_o      = r_pc_o;
        w_valid     = r_valid;
        w_exc       = r_exc;
        w_cause     = r_cause;
        w_mis_entry = 1'b0;

        case (r_state)
            S_REQ, S_KILL: begin
                if (redirect_i) begin
                    w_pc = w_target;
                    // A misaligned target waits for any open cycle to close first
                    if (w_done && w_tgt_mis) begin
                        w_mis_entry = 1'b1;
                    end else if (w_done) begin
                        w_state = S_REQ;
                    end else begin
                        w_state = S_KILL;
                    end
                end else if (w_done) begin
                    if (r_state == S_KILL) begin
                        if (w_pc_mis) begin
                            w_mis_entry = 1'b1;
                        end else begin
                            w_state = S_REQ;
                        end
                    end else begin
                        w_state = S_HOLD;
                        w_valid = 1'b1;
                        w_pc_o  = r_pc;
                        if (!w_ack && c_exc_en) begin
                            w_inst  = c_nop;
                            w_exc   = 1'b1;
                            w_cause = 4'd1;
                        end else begin
                            w_inst  = w_ack ? iwbm_dat_i : c_nop;
                            w_exc   = 1'b0;
                            w_cause = 4'd0;
                        end
                    end
                end
            end
            S_HOLD: begin
                if (redirect_i) begin
                    w_valid = 1'b0;
                    w_pc    = w_target;
                    if (w_tgt_mis) begin
                        w_mis_entry = 1'b1;
                    end else begin
                        w_state = S_REQ;
                    end
                end else if (r_valid && inst_ready_i) begin
                    w_valid = 1'b0;
                    // An accepted exception parks the stage until execute redirects it
                    if (!r_exc) begin
                        w_pc    = r_pc + 32'd4;
                        w_state = S_REQ;
                    end
                end
            end
            default: begin
                w_state = S_REQ;
            end
        endcase

        if (w_mis_entry) begin
            w_state = S_HOLD;
            w_valid = 1'b1;
            w_inst  = c_nop;
            w_pc_o  = w_pc;
            w_exc   = 1'b1;
            w_cause = 4'd0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_REQ;
            r_pc    <= RESET_ADDR;
            r_cyc   <= 1'b0;
            r_inst  <= c_nop;
            r_pc_o  <= RESET_ADDR;
            r_valid <= 1'b0;
            r_exc   <= 1'b0;
            r_cause <= 4'd0;
        end else begin
            r_state <= w_state;
            r_pc    <= w_pc;
            r_cyc   <= (w_state != S_HOLD);
            r_inst  <= w_inst;
            r_pc_o  <= w_pc_o;
            r_valid <= w_valid;
            r_exc   <= w_exc;
            r_cause <= w_cause;
        end
    end

    assign iwbm_addr_o  = {r_pc[31:2], 2'b00};
    assign iwbm_cyc_o   = r_cyc;
    assign iwbm_stb_o   = r_cyc;
    assign inst_o       = r_inst;
    assign pc_o         = r_pc_o;
    assign inst_valid_o = r_valid;
    assign exc_o        = r_exc;
    assign exc_cause_o  = r_cause;

endmodule
`default_nettype wire

// File: tb/tb_morty_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_morty_fetch_unit
// Description : Directed self-checking bench for morty_fetch_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_morty_fetch_unit;

    logic        clk;
    logic        rst;
    logic [31:0] addr;
    logic        cyc;
    logic        stb;
    logic [31:0] dat;
    logic        ack;
    logic        err;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] inst;
    logic [31:0] pc_out;
    logic        valid;
    logic        ready;
    logic        exc;
    logic [3:0]  cause;

    int n_chk  = 0;
    int n_pass = 0;

    morty_fetch_unit #(.RESET_ADDR(32'h8000_0000)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .iwbm_addr_o   (addr),
        .iwbm_cyc_o    (cyc),
        .iwbm_stb_o    (stb),
        .iwbm_dat_i    (dat),
        .iwbm_ack_i    (ack),
        .iwbm_err_i    (err),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .inst_o        (inst),
        .pc_o          (pc_out),
        .inst_valid_o  (valid),
        .inst_ready_i  (ready),
        .exc_o         (exc),
        .exc_cause_o   (cause)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; dat = 32'h0; ack = 1'b0; err = 1'b0;
        redirect = 1'b0; redirect_pc = 32'h0; ready = 1'b0;
        tick; tick;
        check("rst_cyc",   {31'd0, cyc},   32'd0);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_inst",  inst,           32'h0000_0013);
        check("rst_pc",    pc_out,         32'h8000_0000);
        check("rst_exc",   {27'd0, exc, cause}, 32'd0);

        // Back-to-back fetch, zero-wait ack, ready high
        rst = 1'b0; ready = 1'b1;
        tick;
        for (int i = 0; i < 3; i++) begin
            check("seq_cyc",  {30'd0, cyc, stb}, 32'd3);
            check("seq_addr", addr, 32'h8000_0000 + 32'(4 * i));
            dat = 32'h1000_0093 + 32'(i << 20); ack = 1'b1;
            tick;
            ack = 1'b0;
            check("seq_valid", {31'd0, valid}, 32'd1);
            check("seq_inst",  inst,   32'h1000_0093 + 32'(i << 20));
            check("seq_pc",    pc_out, 32'h8000_0000 + 32'(4 * i));
            check("seq_hold_cyc", {31'd0, cyc}, 32'd0);
            tick;
            check("seq_next_valid", {31'd0, valid}, 32'd0);
        end

        // Decode stalls for 5 cycles
        check("stall_addr", addr, 32'h8000_000C);
        ready = 1'b0; dat = 32'h00C0_0513; ack = 1'b1;
        tick;
        ack = 1'b0; dat = 32'hDEAD_BEEF;
        for (int i = 0; i < 5; i++) begin
            check("stall_vc",   {30'd0, valid, cyc}, 32'd2);
            check("stall_inst", inst,   32'h00C0_0513);
            check("stall_pc",   pc_out, 32'h8000_000C);
            tick;
        end
        ready = 1'b1;
        tick;
        check("stall_next", addr, 32'h8000_0010);

        // Slow slave, redirect mid-cycle, late ack discarded
        tick;
        redirect = 1'b1; redirect_pc = 32'h8000_0100;
        tick;
        redirect = 1'b0;
        check("kill_cyc", {31'd0, cyc}, 32'd1);
        tick;
        dat = 32'hBAD0_0001; ack = 1'b1;
        tick;
        ack = 1'b0;
        check("kill_valid", {31'd0, valid}, 32'd0);
        check("kill_addr",  addr, 32'h8000_0100);
        check("kill_cyc2",  {31'd0, cyc}, 32'd1);
        dat = 32'h0010_0113; ack = 1'b1;
        tick;
        ack = 1'b0;
        check("kill_inst", inst,   32'h0010_0113);
        check("kill_pc",   pc_out, 32'h8000_0100);
        tick;

        // Redirect together with ack
        check("rdack_addr", addr, 32'h8000_0104);
        dat = 32'hBAD0_0002; ack = 1'b1; redirect = 1'b1; redirect_pc = 32'h8000_0200;
        tick;
        ack = 1'b0; redirect = 1'b0;
        check("rdack_vc",   {30'd0, valid, cyc}, 32'd1);
        check("rdack_addr2", addr, 32'h8000_0200);

        // Redirect during HOLD with ready high
        dat = 32'h0020_0193; ack = 1'b1;
        tick;
        ack = 1'b0;
        check("rdh_valid", {31'd0, valid}, 32'd1);
        redirect = 1'b1; redirect_pc = 32'h8000_0300;
        tick;
        redirect = 1'b0;
        check("rdh_vc",   {30'd0, valid, cyc}, 32'd1);
        check("rdh_addr", addr, 32'h8000_0300);
        dat = 32'h0030_0213; ack = 1'b1;
        tick;
        ack = 1'b0;
        check("rdh_pc", pc_out, 32'h8000_0300);

        // PC wrap
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick;
        redirect = 1'b0;
        check("wrap_addr", addr, 32'hFFFF_FFFC);
        dat = 32'h0040_0293; ack = 1'b1;
        tick;
        ack = 1'b0;
        check("wrap_pc", pc_out, 32'hFFFF_FFFC);
        tick;
        check("wrap_next", addr, 32'h0000_0000);
        dat = 32'h0050_0313; ack = 1'b1;
        tick;
        ack = 1'b0; ready = 1'b0;

        // Misaligned redirect and bus error
        redirect = 1'b1; redirect_pc = 32'h8000_0102;
        tick;
        redirect = 1'b0;
`ifdef MORTY_IF_EXC_EN
        check("mis_vc",    {30'd0, valid, cyc}, 32'd2);
        check("mis_exc",   {27'd0, exc, cause}, 32'h10);
        check("mis_pc",    pc_out, 32'h8000_0102);
        check("mis_inst",  inst,   32'h0000_0013);
        ready = 1'b1;
        tick;
        tick;
        check("mis_park", {30'd0, valid, cyc}, 32'd0);
        redirect = 1'b1; redirect_pc = 32'h8000_0400;
        tick;
        redirect = 1'b0;
        check("err_addr", addr, 32'h8000_0400);
        ready = 1'b0; err = 1'b1;
        tick;
        err = 1'b0;
        check("err_valid", {31'd0, valid}, 32'd1);
        check("err_exc",   {27'd0, exc, cause}, 32'h11);
        check("err_inst",  inst,   32'h0000_0013);
        check("err_pc",    pc_out, 32'h8000_0400);
`else
        check("mis_vc",   {30'd0, valid, cyc}, 32'd1);
        check("mis_addr", addr, 32'h8000_0100);
        err = 1'b1; dat = 32'hBAD0_0003;
        tick;
        err = 1'b0;
        check("err_valid", {31'd0, valid}, 32'd1);
        check("err_inst",  inst,   32'h0000_0013);
        check("err_pc",    pc_out, 32'h8000_0100);
        check("err_exc",   {27'd0, exc, cause}, 32'd0);
`endif

        // Reset in the middle of a bus cycle, then a stray late ack
        redirect = 1'b1; redirect_pc = 32'h8000_0500;
        tick;
        redirect = 1'b0;
        check("mrst_pre", {31'd0, cyc}, 32'd1);
        rst = 1'b1;
        tick;
        check("mrst_vc", {30'd0, valid, cyc}, 32'd0);
        rst = 1'b0; ack = 1'b1; dat = 32'hBAD0_0004;
        tick;
        ack = 1'b0;
        check("mrst_vc2",  {30'd0, valid, cyc}, 32'd1);
        check("mrst_addr", addr, 32'h8000_0000);
        check("mrst_inst", inst, 32'h0000_0013);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/morty_fetch_unit.md
# morty_fetch_unit

Instruction fetch stage of the Morty RV32I core. Owns the program counter and runs a Wishbone classic read master on the instruction bus. It holds each fetched word in an instruction register and presents it to decode with a valid/ready handshake. Decode slices `inst_o[31:7]` straight into the immediate extender, so `inst_o` must stay stable while valid. Branch and jump redirects from execute can arrive at any time, including mid-bus-cycle.

## Interface
- `RESET_ADDR`, default `32'h8000_0000`: PC loaded on reset.
- `clk_i` in 1: single clock, rising edge.
- `rst_i` in 1: synchronous, active-high reset.
- `iwbm_addr_o` out 32: fetch address, always word-aligned.
- `iwbm_cyc_o` out 1: Wishbone cycle.
- `iwbm_stb_o` out 1: Wishbone strobe, equal to `cyc`.
- `iwbm_dat_i` in 32: read data.
- `iwbm_ack_i` in 1: transfer done.
- `iwbm_err_i` in 1: bus error.
- `redirect_i` in 1: one-cycle pulse that restarts fetch.
- `redirect_pc_i` in 32: redirect target.
- `inst_o` out 32: held instruction.
- `pc_o` out 32: address of `inst_o`.
- `inst_valid_o` out 1: instruction available.
- `inst_ready_i` in 1: decode accepts.
- `exc_o` out 1: fetch exception attached to `inst_o`.
- `exc_cause_o` out 4: RISC-V cause; 0 = misaligned fetch, 1 = access fault.

## Operation
- States:
  - `S_REQ`: bus cycle active at `pc`.
  - `S_HOLD`: `inst_valid_o` = 1, instruction held.
  - `S_KILL`: bus cycle active; its result is discarded.
- `cyc`/`stb` = 1 in `S_REQ` and `S_KILL`. They stay high until `ack` or `err`, per the classic protocol.
- `S_REQ`:
  - `ack` → latch `dat_i` into `inst_o`, `pc_o` = `pc`, `exc_o` = 0, go to `S_HOLD`.
  - `err` → see Configuration.
- `S_HOLD`:
  - `inst_valid_o` & `inst_ready_i` → `pc` += 4 (mod 2^32, wraps `FFFF_FFFC` → `0000_0000`), go to `S_REQ`.
  - No ready → hold `inst_o`, `pc_o`, `exc_*` unchanged.
- Redirect has priority over every other event:
  - In `S_REQ` or `S_KILL` without `ack`/`err` in the same cycle: `pc` ← target, go to `S_KILL`.
  - In `S_REQ` or `S_KILL` with `ack`/`err` in the same cycle: discard the data, `pc` ← target, go to `S_REQ`.
  - In `S_HOLD`: the held instruction is dropped, whether or not `inst_ready_i` is high; `inst_valid_o` = 0 next cycle, `pc` ← target, go to `S_REQ`.
- `S_KILL`:
  - `ack`/`err` → discard, go to `S_REQ` at the latched `pc`.
  - Repeated redirects in `S_KILL` keep only the latest target.
- `iwbm_addr_o` = `{pc[31:2], 2'b00}`.

## Timing
- Reset values:
  - `pc` = `RESET_ADDR`, state = `S_REQ`.
  - `cyc`/`stb` = 0, `inst_valid_o` = 0.
  - `inst_o` = `32'h0000_0013` (NOP), `pc_o` = `RESET_ADDR`.
  - `exc_o` = 0, `exc_cause_o` = 0.
- Timing after reset and for each fetch:
  - `cyc`/`stb` assert in the first cycle after `rst_i` deasserts.
  - `ack` in cycle N → `inst_valid_o` in cycle N+1.
  - Peak throughput is one instruction per 2 cycles (`REQ`, `HOLD`), assuming `ack` in the same cycle as `stb` and ready tied high.
- `rst_i` mid-cycle drops `cyc`/`stb` at the next edge; a late `ack` arriving afterward is ignored.
- All outputs are registered except `stb`, which is a copy of the registered `cyc`.

## Configuration
- `MORTY_IF_EXC_EN` defined:
  - A redirect target with `[1:0]` ≠ 0 issues no bus cycle. The block goes directly to `S_HOLD` with `exc_o` = 1, `exc_cause_o` = 0, `inst_o` = NOP, `pc_o` = the unaligned target.
  - `err` in `S_REQ` → `S_HOLD` with `exc_o` = 1, `exc_cause_o` = 1, `inst_o` = NOP.
  - On handshake of an exception entry, `pc` is not advanced. The block waits in `S_HOLD` with `inst_valid_o` = 0 until the next redirect.
- `MORTY_IF_EXC_EN` undefined:
  - Redirect target bits `[1:0]` are cleared.
  - `err` is treated as `ack` with data = NOP.
  - `exc_o` and `exc_cause_o` are tied to 0.

## Test plan
- Reset release, `RESET_ADDR` = `8000_0000`, `ack` in the same cycle as `stb`, ready = 1 → addresses `8000_0000`, `8000_0004`, `8000_0008`. `inst_o` matches memory, with one instruction per 2 cycles.
- `ack` with data `0x00C0_0513`, ready held low for 5 cycles → `inst_valid_o`, `inst_o`, and `pc_o` stay constant; `cyc` = 0 throughout.
- Redirect to `8000_0100` while `S_REQ` waits 3 cycles for `ack` → the late data is never valid; the next `cyc` address is `8000_0100`.
- Redirect in the same cycle as `ack`, and separately redirect during `S_HOLD` with ready = 1 → neither word is delivered; the next fetch is at the target.
- PC at `FFFF_FFFC` accepted → next address `0000_0000`.
- With the macro: redirect to `8000_0102` → `exc_o` = 1, cause 0, no bus cycle. `err` → cause 1. Without the macro: fetch at `8000_0100`, and `err` yields a NOP.
